rv32i_single_cycle_core: RTL and testbench
==========================================

Name: rv32i_single_cycle_core

Overview:
- Single-cycle RV32I integer core; executes one instruction per clock.
- Fetches from an external combinational program memory: drives pc, receives the instruction in the same cycle.
- Accesses an external byte-enabled data RAM: combinational read, write on the rising clock edge.
- Top-level processing element of the SoC; branch/jump correctness is the primary verification target.

Parameters:
- RESET_PC, 32'h0000_0000, pc value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-high reset (asserted = 1, despite the name).
- instruction  input  32  instruction word at the current pc.
- pc  output  32  address of the instruction being executed.
- memory_address  output  32  data address = rs1 + imm (loads/stores); 0 otherwise.
- memory_out  input  32  word read from RAM at memory_address (combinational).
- memory_write  output  32  store data, shifted into the addressed byte lanes.
- memory_byte_enable  output  4  active byte lanes for the current access.
- memory_we  output  1  write strobe; RAM writes at the next rising edge.

Behaviour:
- Reset while rst_n=1: pc=RESET_PC; all 31 registers x1..x31 cleared to 0; memory_we forced 0; memory_byte_enable=0.
- Reset mid-program: pc returns to RESET_PC immediately (asynchronous); execution restarts on the first rising edge after deassertion.
- Each edge: pc <= next_pc; the rd write and the RAM store commit on the same edge.
- Register file:
  - 32x32; x0 reads 0 and ignores writes.
  - Reads are combinational.
  - No bypass needed: single cycle.
- Supported opcodes: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Immediates: standard RV32I I/S/B/U/J formats, sign-extended.
- Shifts use the low 5 bits of the amount; SRA/SRAI are arithmetic.
- Arithmetic wraps modulo 2^32.
- next_pc:
  - default pc+4.
  - Taken branch: pc + B-imm.
  - JAL: pc + J-imm.
  - JALR: (rs1 + I-imm) with bit0 cleared.
  - JAL/JALR write pc+4 to rd; rd is written even if rd equals rs1, using the old rs1 value.
- Branch compare:
  - BLT/BGE signed; BLTU/BGEU unsigned.
  - BGE/BGEU taken when equal.
- Stores: memory_we=1; byte_enable and memory_write by width.
  - SB: enable = 0001 << addr[1:0]; data = rs2[7:0] replicated in all lanes.
  - SH: enable = 0011 << (addr[1]*2); data = rs2[15:0] replicated in both halves.
  - SW: enable = 1111; data = rs2.
  - Misaligned low address bits are ignored per the width rule above; no trap.
- Loads:
  - byte_enable set as for stores; memory_we=0.
  - Result is taken from the lane selected by addr[1:0] (LH/LHU use addr[1]; LW ignores the low bits).
  - Sign- or zero-extended per funct3.
- Non-memory instructions: memory_we=0, byte_enable=0, memory_write=0.
- FENCE, ECALL, EBREAK, and any unrecognised encoding: execute as NOP (pc+4, no register or memory write).
- Branch/jump targets are not alignment-checked; pc bits [1:0] propagate as computed.

Test Plan:
- Reset and sequential fetch: hold rst_n=1 for 20 ns, release -> pc=0 during reset, then 4, 8, 12 on successive edges; memory_we=0 throughout reset.
- Taken/not-taken branches: x1=5 and x2=5 via ADDI; BEQ x1,x2,+8 -> pc skips one instruction; BNE x1,x2,+8 -> pc+4.
- Signed vs unsigned compare: x1=-1, x2=1 -> BLT taken, BLTU not taken, BGEU taken, BGE not taken.
- Jumps: JAL x1,+16 at pc=0x20 -> pc=0x30, x1=0x24; JALR x0,0(x1) -> pc=0x24, x0 remains 0.
- Memory lanes: SB of x5=0xAB to address 0x101 -> byte_enable=0010, write data 0xABABABAB; LB from 0x101 -> 0xFFFFFFAB; LBU from 0x101 -> 0x000000AB; SW then LW at 0x100 round-trips.
- Mid-run reset: assert rst_n=1 asynchronously while pc=0x40 -> pc=0 immediately; registers read 0 after release.

Source files
------------

// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I integer core.
// Combinational fetch/load, stores and rd writes commit on the rising edge.
module rv32i_single_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] memory_address,
  input  logic [31:0] memory_out,
  output logic [31:0] memory_write,
  output logic [3:0]  memory_byte_enable,
  output logic        memory_we
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];
  logic        rd_we;
  logic [31:0] rd_d;

  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opc = instruction[6:0];
  assign rd  = instruction[11:7];
  assign f3  = instruction[14:12];
  assign rs1 = instruction[19:15];
  assign rs2 = instruction[24:20];
  assign f7  = instruction[31:25];

  logic [31:0] rs1_v, rs2_v;
  assign rs1_v = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_v = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25],
                  instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31],
                  instruction[7], instruction[30:25],
                  instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'd0};
  assign imm_j = {{11{instruction[31]}}, instruction[31],
                  instruction[19:12], instruction[20],
                  instruction[30:21], 1'b0};

  // Illegal funct fields fall through to the NOP default
  logic is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic is_ld, is_st, is_op, is_opi, is_alu;
  assign is_lui   = opc == 7'h37;
  assign is_auipc = opc == 7'h17;
  assign is_jal   = opc == 7'h6f;
  assign is_jalr  = opc == 7'h67 && f3 == 3'd0;
  assign is_br    = opc == 7'h63 && f3[2:1] != 2'b01;
  assign is_ld    = opc == 7'h03 && f3 != 3'd3 &&
                    f3[2:1] != 2'b11;
  assign is_st    = opc == 7'h23 && !f3[2] && f3[1:0] != 2'b11;
  assign is_opi   = opc == 7'h13 &&
                    (f3 == 3'd1 ? f7 == 7'h00 :
                     f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) :
                     1'b1);
  assign is_op    = opc == 7'h33 &&
                    (f7 == 7'h00 ||
                     (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
  assign is_alu   = is_op || is_opi;

  logic [31:0] alu_b, alu_r;
  logic [4:0]  shamt;
  assign alu_b = is_op ? rs2_v : imm_i;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_r = '0;
    case (f3)
      3'd0: alu_r = (is_op && f7[5]) ? rs1_v - alu_b
                                     : rs1_v + alu_b;
      3'd1: alu_r = rs1_v << shamt;
      3'd2: alu_r = {31'd0, $signed(rs1_v) < $signed(alu_b)};
      3'd3: alu_r = {31'd0, rs1_v < alu_b};
      3'd4: alu_r = rs1_v ^ alu_b;
      3'd5: alu_r = f7[5] ? $unsigned($signed(rs1_v) >>> shamt)
                          : rs1_v >> shamt;
      3'd6: alu_r = rs1_v | alu_b;
      3'd7: alu_r = rs1_v & alu_b;
      default: alu_r = '0;
    endcase
  end

  logic take;
  always_comb begin
    take = 1'b0;
    case (f3)
      3'd0: take = rs1_v == rs2_v;
      3'd1: take = rs1_v != rs2_v;
      3'd4: take = $signed(rs1_v) < $signed(rs2_v);
      3'd5: take = $signed(rs1_v) >= $signed(rs2_v);
      3'd6: take = rs1_v < rs2_v;
      3'd7: take = rs1_v >= rs2_v;
      default: take = 1'b0;
    endcase
  end

  logic [31:0] mem_addr, st_data, ld_val;
  logic [3:0]  lane_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  assign mem_addr = rs1_v + (is_st ? imm_s : imm_i);
  assign ld_byte  = memory_out[{mem_addr[1:0], 3'b000} +: 8];
  assign ld_half  = memory_out[{mem_addr[1], 4'b0000} +: 16];

  always_comb begin
    lane_be = 4'b1111;
    st_data = rs2_v;
    case (f3[1:0])
      2'd0: begin
        lane_be = 4'b0001 << mem_addr[1:0];
        st_data = {4{rs2_v[7:0]}};
      end
      2'd1: begin
        lane_be = 4'b0011 << {mem_addr[1], 1'b0};
        st_data = {2{rs2_v[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (f3)
      3'd0:    ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_val = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_val = {24'd0, ld_byte};
      3'd5:    ld_val = {16'd0, ld_half};
      default: ld_val = memory_out;
    endcase
  end

  logic [31:0] pc4, mem_ad, mem_wd;
  logic [3:0]  mem_be;
  logic        mem_we;
  assign pc4 = pc_q + 32'd4;

  always_comb begin
    pc_d   = pc4;
    rd_we  = 1'b0;
    rd_d   = '0;
    mem_ad = '0;
    mem_wd = '0;
    mem_be = '0;
    mem_we = 1'b0;
    unique case (1'b1)
      is_lui: begin
        rd_we = 1'b1;
        rd_d  = imm_u;
      end
      is_auipc: begin
        rd_we = 1'b1;
        rd_d  = pc_q + imm_u;
      end
      is_jal: begin
        rd_we = 1'b1;
        rd_d  = pc4;
        pc_d  = pc_q + imm_j;
      end
      is_jalr: begin
        rd_we = 1'b1;
        rd_d  = pc4;
        pc_d  = (rs1_v + imm_i) & ~32'd1;
      end
      is_br: begin
        if (take) pc_d = pc_q + imm_b;
      end
      is_ld: begin
        rd_we  = 1'b1;
        rd_d   = ld_val;
        mem_ad = mem_addr;
        mem_be = lane_be;
      end
      is_st: begin
        mem_ad = mem_addr;
        mem_be = lane_be;
        mem_wd = st_data;
        mem_we = 1'b1;
      end
      is_alu: begin
        rd_we = 1'b1;
        rd_d  = alu_r;
      end
      default: ;
    endcase
  end

  // rst_n is active high: asserted means held in reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (rd_we && rd != 5'd0) rf_q[rd] <= rd_d;
    end
  end

  assign pc                 = pc_q;
  assign memory_address     = mem_ad;
  assign memory_write       = mem_wd;
  assign memory_byte_enable = rst_n ? 4'b0000 : mem_be;
  assign memory_we          = mem_we & ~rst_n;

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Bench for rv32i_single_cycle_core: program ROM + byte RAM models,
// expected per-cycle pc/memory outputs queued and compared on negedge.
module tb_rv32i_single_cycle_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] memory_address;
  logic [31:0] memory_out;
  logic [31:0] memory_write;
  logic [3:0]  memory_byte_enable;
  logic        memory_we;

  rv32i_single_cycle_core #(.RESET_PC(32'h0)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .instruction        (instruction),
    .pc                 (pc),
    .memory_address     (memory_address),
    .memory_out         (memory_out),
    .memory_write       (memory_write),
    .memory_byte_enable (memory_byte_enable),
    .memory_we          (memory_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem [64];
  logic [31:0] dmem [256];
  assign instruction = imem[pc[7:2]];
  assign memory_out  = dmem[memory_address[9:2]];

  always @(posedge clk) begin
    if (memory_we)
      for (int b = 0; b < 4; b++)
        if (memory_byte_enable[b])
          dmem[memory_address[9:2]][8*b +: 8] <=
            memory_write[8*b +: 8];
  end

  int n_chk;
  int n_pass;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] pc;
    int          kind;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } exp_t;

  exp_t sbq [$];

  task automatic push(input string tag, input logic [31:0] p,
                      input int kind, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    e.tag = tag; e.pc = p; e.kind = kind;
    e.addr = a; e.wd = wd; e.be = be;
    sbq.push_back(e);
  endtask

  task automatic pn(input string tag, input logic [31:0] p);
    push(tag, p, 0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic run_sb();
    exp_t e;
    while (sbq.size() > 0) begin
      @(negedge clk);
      e = sbq.pop_front();
      chk({e.tag, "_pc"}, pc, e.pc);
      chk({e.tag, "_be"}, {28'd0, memory_byte_enable},
          {28'd0, e.be});
      chk({e.tag, "_we"}, {31'd0, memory_we},
          {31'd0, e.kind == 2});
      chk({e.tag, "_addr"}, memory_address, e.addr);
      if (e.kind != 1)
        chk({e.tag, "_wd"}, memory_write, e.wd);
    end
  endtask

  function automatic logic [31:0] ei(int imm, int r1, int f3,
                                     int rd, int op);
    logic [31:0] m, a, f, d, o;
    m = imm; a = r1; f = f3; d = rd; o = op;
    return {m[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] es(int imm, int r2, int r1,
                                     int f3);
    logic [31:0] m, a, b, f;
    m = imm; a = r1; b = r2; f = f3;
    return {m[11:5], b[4:0], a[4:0], f[2:0], m[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] eb(int imm, int r2, int r1,
                                     int f3);
    logic [31:0] m, a, b, f;
    m = imm; a = r1; b = r2; f = f3;
    return {m[12], m[10:5], b[4:0], a[4:0], f[2:0],
            m[4:1], m[11], 7'h63};
  endfunction

  function automatic logic [31:0] ej(int imm, int rd);
    logic [31:0] m, d;
    m = imm; d = rd;
    return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'h6f};
  endfunction

  function automatic logic [31:0] er(int f7, int r2, int r1,
                                     int f3, int rd);
    logic [31:0] s, a, b, f, d;
    s = f7; a = r1; b = r2; f = f3; d = rd;
    return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] eu(int imm, int rd, int op);
    logic [31:0] m, d, o;
    m = imm; d = rd; o = op;
    return {m[19:0], d[4:0], o[6:0]};
  endfunction

  logic [31:0] pa;
  task automatic put(input logic [31:0] w);
    imem[pa[7:2]] = w;
    pa = pa + 32'd4;
  endtask

  int          sr [15] = '{9, 10, 12, 1, 3, 13, 14, 15,
                           16, 17, 18, 19, 20, 21, 0};
  logic [31:0] sv [15] = '{32'hFFFF_FFAB, 32'h0000_00AB,
                           32'h1234_5678, 32'h0000_0024,
                           32'h0, 32'h2, 32'hFFFF_FFFF,
                           32'hF, 32'h1, 32'h0,
                           32'hEDCB_A987, 32'h8000_0000,
                           32'h0000_5678, 32'h0000_1088,
                           32'h0};

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    imem[0] = es(0, 0, 0, 2);

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_we", {31'd0, memory_we}, 32'd0);
      chk("rst_be", {28'd0, memory_byte_enable}, 32'd0);
    end

    pa = 32'h0;
    put(ei(5, 0, 0, 1, 8'h13));
    put(ei(5, 0, 0, 2, 8'h13));
    put(ei(8'hAB, 0, 0, 5, 8'h13));
    put(eb(8, 2, 1, 0));
    put(ei(1, 0, 0, 3, 8'h13));
    put(eb(8, 2, 1, 1));
    put(ei(-1, 0, 0, 6, 8'h13));
    put(ei(1, 0, 0, 7, 8'h13));
    put(ej(16, 1));
    put(eb(8, 7, 6, 4));
    put(ei(2, 0, 0, 3, 8'h13));
    put(eb(8, 7, 6, 7));
    put(ei(0, 1, 0, 0, 8'h67));
    put(eb(8, 7, 6, 6));
    put(eb(8, 7, 6, 5));
    put(ej(8, 0));
    put(32'h0000_0013);
    put(ei(256, 0, 0, 8, 8'h13));
    put(es(1, 5, 8, 0));
    put(ei(1, 8, 0, 9, 3));
    put(ei(1, 8, 4, 10, 3));
    put(eu(32'h12345, 11, 8'h37));
    put(ei(32'h678, 11, 0, 11, 8'h13));
    put(es(0, 11, 8, 2));
    put(ei(0, 8, 2, 12, 3));
    put(er(32'h20, 6, 7, 0, 13));
    put(ei(32'h404, 6, 5, 14, 8'h13));
    put(ei(28, 6, 5, 15, 8'h13));
    put(er(0, 7, 6, 2, 16));
    put(er(0, 7, 6, 3, 17));
    put(ei(-1, 11, 4, 18, 8'h13));
    put(ei(31, 7, 1, 19, 8'h13));
    put(es(2, 11, 8, 1));
    put(ei(2, 8, 1, 20, 3));
    put(eu(1, 21, 8'h17));
    for (int k = 0; k < 15; k++) put(es(4 + 4 * k, sr[k], 8, 2));
    put(ej(-32'sh88, 0));

    pn("seq1", 32'h04);
    pn("seq2", 32'h08);
    pn("seq3", 32'h0C);
    pn("beq_taken", 32'h14);
    pn("bne_not", 32'h18);
    pn("seq4", 32'h1C);
    pn("seq5", 32'h20);
    pn("jal", 32'h30);
    pn("jalr", 32'h24);
    pn("blt_taken", 32'h2C);
    pn("bgeu_taken", 32'h34);
    pn("bltu_not", 32'h38);
    pn("bge_not", 32'h3C);
    pn("jal_fwd", 32'h44);
    push("sb", 32'h48, 2, 32'h101, 32'hABAB_ABAB, 4'b0010);
    push("lb", 32'h4C, 1, 32'h101, 32'h0, 4'b0010);
    push("lbu", 32'h50, 1, 32'h101, 32'h0, 4'b0010);
    pn("lui", 32'h54);
    pn("addi", 32'h58);
    push("sw", 32'h5C, 2, 32'h100, 32'h1234_5678, 4'b1111);
    push("lw", 32'h60, 1, 32'h100, 32'h0, 4'b1111);
    for (int k = 0; k < 7; k++)
      pn($sformatf("alu%0d", k), 32'h64 + 32'(4 * k));
    push("sh", 32'h80, 2, 32'h102, 32'h5678_5678, 4'b1100);
    push("lh", 32'h84, 1, 32'h102, 32'h0, 4'b1100);
    pn("auipc", 32'h88);
    for (int k = 0; k < 15; k++)
      push($sformatf("st_x%0d", sr[k]), 32'h8C + 32'(4 * k), 2,
           32'h104 + 32'(4 * k), sv[k], 4'b1111);
    pn("jal_back", 32'hC8);
    pn("at_40", 32'h40);

    #2 rst_n = 1'b0;
    run_sb();

    #2 rst_n = 1'b1;
    #1 chk("async_rst_pc", pc, 32'h0);
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
    imem[0] = es(32'h104, 5, 0, 2);
    imem[1] = es(32'h108, 11, 0, 2);
    imem[2] = es(32'h10C, 1, 0, 2);

    @(negedge clk);
    chk("rst_hold_pc", pc, 32'h0);
    chk("rst_hold_we", {31'd0, memory_we}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("restart_pc", pc, 32'h0);
    chk("restart_we", {31'd0, memory_we}, 32'd1);
    chk("restart_addr", memory_address, 32'h104);
    chk("x5_cleared", memory_write, 32'h0);
    push("x11_cleared", 32'h04, 2, 32'h108, 32'h0, 4'b1111);
    push("x1_cleared", 32'h08, 2, 32'h10C, 32'h0, 4'b1111);
    pn("restart_nop", 32'h0C);
    run_sb();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
